// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia_if
//   Groups the presentation unit's control and sequence-memory signals.
//   slave  : the presentation unit (exibe_sequencia)
//   master : the game control side plus the sequence memory
//   Signals:
//     iniciar      start request
//     limite       last address to show (0..15)
//     mem_dado     sequence memory read data for mem_endereco
//     mem_endereco sequence memory address
//     leds         player LEDs
//     ocupado      high while a presentation is in progress
//     fim          one-cycle completion pulse
//     db_estado    FSM state code for the debug display
interface exibe_sequencia_if;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_estado;

    modport slave (
        input  iniciar, limite, mem_dado,
        output mem_endereco, leds, ocupado, fim, db_estado
    );

    modport master (
        output iniciar, limite, mem_dado,
        input  mem_endereco, leds, ocupado, fim, db_estado
    );
endinterface

// File: rtl/exibe_sequencia.sv
// exibe_sequencia
//   Shows the stored game sequence: walks addresses 0..limite of the sequence
//   memory, lighting each entry on the LEDs for T_ON cycles followed by a
//   T_OFF-cycle dark gap, then pulses fim for one cycle.
//   Optional macro EXIBE_SEQUENCIA_FLASH_FINAL_EN adds a final all-LEDs-on
//   FLASH state of T_ON cycles before FIM.
//   Ports:
//     clock  system clock, rising edge
//     reset  synchronous, active-high
//     bus    exibe_sequencia_if.slave (iniciar, limite, mem_dado in;
//            mem_endereco, leds, ocupado, fim, db_estado out)
//   Parameters:
//     T_ON   cycles each entry is lit (>=1)
//     T_OFF  cycles of dark gap after each entry (>=1)
module exibe_sequencia #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500
) (
    input  logic               clock,
    input  logic               reset,
    exibe_sequencia_if.slave   bus
);

    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] TON_ULT  = TW'(T_ON - 1);
    localparam logic [TW-1:0] TOFF_ULT = TW'(T_OFF - 1);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        ACESO   = 4'h1,
        APAGADO = 4'h2,
`ifdef EXIBE_SEQUENCIA_FLASH_FINAL_EN
        FLASH   = 4'h3,
`endif
        FIM     = 4'hF
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [3:0]    endereco_q, endereco_d;
    logic [3:0]    limite_q, limite_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    leds;
    logic          ocupado;
    logic          fim;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= '0;
            limite_q   <= '0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        timer_d    = timer_q;
        leds       = '0;
        ocupado    = 1'b0;
        fim        = 1'b0;

        case (estado_q)
            INICIAL: begin
                if (bus.iniciar) begin
                    limite_d   = bus.limite;
                    endereco_d = '0;
                    timer_d    = '0;
                    estado_d   = ACESO;
                end
            end

            ACESO: begin
                leds    = bus.mem_dado;
                ocupado = 1'b1;
                if (timer_q == TON_ULT) begin
                    timer_d  = '0;
                    estado_d = APAGADO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            APAGADO: begin
                ocupado = 1'b1;
                if (timer_q == TOFF_ULT) begin
                    timer_d = '0;
                    // Comparing before incrementing keeps endereco from
                    // wrapping 15 -> 0 on the last entry.
                    if (endereco_q == limite_q) begin
`ifdef EXIBE_SEQUENCIA_FLASH_FINAL_EN
                        estado_d = FLASH;
`else
                        estado_d = FIM;
`endif
                    end else begin
                        endereco_d = endereco_q + 4'd1;
                        estado_d   = ACESO;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

`ifdef EXIBE_SEQUENCIA_FLASH_FINAL_EN
            FLASH: begin
                leds    = '1;
                ocupado = 1'b1;
                if (timer_q == TON_ULT) begin
                    timer_d  = '0;
                    estado_d = FIM;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif

            FIM: begin
                fim      = 1'b1;
                estado_d = INICIAL;
            end

            default: begin
                timer_d  = '0;
                estado_d = INICIAL;
            end
        endcase
    end

    assign bus.mem_endereco = endereco_q;
    assign bus.leds         = leds;
    assign bus.ocupado      = ocupado;
    assign bus.fim          = fim;
    assign bus.db_estado    = estado_q;

endmodule
